instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the decode stage. It owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- It presents Instr/PC/PC+4 to decode and honours decode's branch/jump redirect (Alt_PC, Request_Alt_PC) and freeze (WANT_FREEZE).
- At most one memory request is outstanding. A one-entry hold buffer absorbs a response that lands during a freeze.

Parameters:
- RESET_PC, 32'h0040_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word driven on a bubble.

Ports:
- CLK  in  1  sole clock; all state updates on posedge CLK.
- RESET  in  1  synchronous, active-high reset.
- Alt_PC  in  32  redirect target from decode (registered there).
- Request_Alt_PC  in  1  redirect strobe from decode.
- WANT_FREEZE  in  1  decode stall; hold outputs and do not advance PC.
- IMEM_Addr  out  32  fetch address, word aligned.
- IMEM_Req  out  1  fetch request.
- IMEM_Ack  in  1  one-cycle response strobe; IMEM_Data valid in that cycle.
- IMEM_Data  in  32  fetched word.
- Instr1_OUT  out  32  instruction to decode.
- Instr_PC_OUT  out  32  PC of Instr1_OUT.
- Instr_PC_Plus4_OUT  out  32  Instr_PC_OUT+4.
- Instr_Valid_OUT  out  1  Instr1_OUT is real (0 = bubble).

Behaviour:
- Reset (RESET=1 at posedge):
  - PC=RESET_PC, state=ISSUE, hold buffer empty.
  - Instr1_OUT=NOP_INSTR, Instr_PC_OUT=0, Instr_PC_Plus4_OUT=0, Instr_Valid_OUT=0, IMEM_Req=0.
  - Reset mid-transaction abandons the outstanding request; a later IMEM_Ack for it is ignored because state is no longer DRAIN/ISSUE-with-req.
- IMEM_Addr=PC at all times. IMEM_Req is combinational: 1 in ISSUE and DRAIN unless the hold buffer is full.
- Memory handshake:
  - Req stays high and Addr stays stable until Ack.
  - Zero-wait memory (Ack in the same cycle as Req) is legal.
- States:
  - ISSUE: request outstanding for PC.
  - DRAIN: request outstanding whose response must be discarded; Addr=stale PC held.
  - FULL: hold buffer occupied, no request.
- Priority at each edge: RESET > Request_Alt_PC > WANT_FREEZE > normal.
- ISSUE, normal, Ack=1:
  - Outputs <= {IMEM_Data, PC, PC+4}, Instr_Valid_OUT=1.
  - PC <= PC+4 (32-bit wrap; 32'hFFFF_FFFC+4 = 0).
- ISSUE, normal, Ack=0: Instr_Valid_OUT <= 0, Instr1_OUT <= NOP_INSTR; PC and other outputs hold.
- ISSUE, WANT_FREEZE=1:
  - All outputs hold.
  - If Ack=1: data and PC go to the hold buffer, PC <= PC+4, state to FULL, Req drops.
- FULL:
  - Freeze held: stay in FULL.
  - Freeze low: outputs <= hold buffer (valid=1), buffer empties, state to ISSUE.
- Redirect (Request_Alt_PC=1):
  - Any accepted Ack data this edge is discarded, and the hold buffer is cleared.
  - Outputs: bubble (valid=0, NOP_INSTR) unless WANT_FREEZE=1, in which case they hold.
  - ISSUE with Ack=1, or FULL: PC <= Alt_PC, state ISSUE.
  - ISSUE with Ack=0: capture Alt_PC into PC_next register, state DRAIN.
  - DRAIN: PC_next <= Alt_PC (latest redirect wins).
- DRAIN with Ack=1: discard data, PC <= PC_next, state ISSUE, outputs bubble.
- Alt_PC[1:0] is forced to 0 (alignment).
- Latency: redirect at edge N with a zero-wait memory → first target instruction valid at edge N+1.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output Fetch_Count (32) and output Squash_Count (32), both reset to 0.
  - Fetch_Count increments on every Ack whose data is delivered or buffered.
  - Squash_Count increments on every discarded Ack and on every redirect that clears a full buffer.
  - Both wrap at 2^32.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then zero-wait memory returning Addr as data for 4 cycles → Instr1_OUT/Instr_PC_OUT = 0x00400000, 0x00400004, 0x00400008, 0x0040000C on successive edges; Instr_PC_Plus4_OUT = PC+4; valid=1.
- Memory with 2-cycle Ack latency → Req held, Addr stable at 0x00400000 until Ack; valid=0 between responses.
- Request_Alt_PC=1, Alt_PC=0x00400100 while Ack=0 → DRAIN; stale response discarded; next Addr=0x00400100; first delivered PC=0x00400100.
- WANT_FREEZE=1 for 3 cycles with Ack arriving in cycle 1 → outputs unchanged, Req drops after buffering; on release, buffered instr 0x00400004 appears with valid=1, no fetch lost or duplicated.
- Redirect while FULL and frozen → buffer dropped, PC=Alt_PC; after release, first valid output is at Alt_PC.
- RESET asserted during an outstanding request, then late Ack → ignored; first output after reset is from PC=0x00400000.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- fetch stage feeding the decode stage.
//
// Owns the program counter and fetches one word at a time from instruction
// memory over a req/ack handshake. At most one request is outstanding. A
// one-entry hold buffer keeps a response that arrives while decode is frozen.
//
// Ports:
//   CLK                 sole clock, all state changes on its rising edge
//   RESET               synchronous active-high reset
//   Alt_PC              redirect target from decode (low two bits ignored)
//   Request_Alt_PC      redirect strobe from decode
//   WANT_FREEZE         decode stall: hold outputs, do not advance
//   IMEM_Addr           fetch address (always the PC register)
//   IMEM_Req            fetch request
//   IMEM_Ack            one-cycle response strobe
//   IMEM_Data           fetched word, valid with IMEM_Ack
//   Instr1_OUT          instruction to decode (NOP_INSTR on a bubble)
//   Instr_PC_OUT        PC of Instr1_OUT
//   Instr_PC_Plus4_OUT  Instr_PC_OUT + 4
//   Instr_Valid_OUT     Instr1_OUT carries a real instruction
//
// Optional feature, macro FETCH_PERF_CNT_EN:
//   Fetch_Count         acks whose data was delivered or buffered
//   Squash_Count        discarded acks plus redirects that drop a full buffer
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC,
    input  logic        Request_Alt_PC,
    input  logic        WANT_FREEZE,
    output logic [31:0] IMEM_Addr,
    output logic        IMEM_Req,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_Data,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Instr_Valid_OUT
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] Fetch_Count,
    output logic [31:0] Squash_Count
`endif
);

    // ISSUE: request outstanding for pc_reg.
    // DRAIN: request outstanding whose response is thrown away; the target
    //        waits in redirect_pc_reg while IMEM_Addr keeps the stale PC.
    // FULL : hold buffer occupied, no request.
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] redirect_pc_reg;
    logic [31:0] buf_instr_reg;
    logic [31:0] buf_pc_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_pc_reg;
    logic [31:0] instr_pc_plus4_reg;
    logic        instr_valid_reg;

    logic [31:0] alt_aligned;
    logic [31:0] pc_plus4;
    logic        unused_alt_bits;

    assign alt_aligned     = {Alt_PC[31:2], 2'b00};
    assign unused_alt_bits = ^Alt_PC[1:0];
    assign pc_plus4        = pc_reg + 32'd4;

    assign IMEM_Addr = pc_reg;
    // Request is dropped while reset is held so an in-flight fetch is
    // abandoned cleanly, and while the hold buffer is occupied.
    assign IMEM_Req  = !RESET && (state_reg != ST_FULL);

    assign Instr1_OUT         = instr_reg;
    assign Instr_PC_OUT       = instr_pc_reg;
    assign Instr_PC_Plus4_OUT = instr_pc_plus4_reg;
    assign Instr_Valid_OUT    = instr_valid_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg          <= ST_ISSUE;
            pc_reg             <= RESET_PC;
            redirect_pc_reg    <= RESET_PC;
            buf_instr_reg      <= NOP_INSTR;
            buf_pc_reg         <= 32'd0;
            instr_reg          <= NOP_INSTR;
            instr_pc_reg       <= 32'd0;
            instr_pc_plus4_reg <= 32'd0;
            instr_valid_reg    <= 1'b0;
        end else begin
            // Bubble unless frozen; a freeze always keeps the outputs as-is.
            // Branches below override this when an instruction is delivered.
            if (!WANT_FREEZE) begin
                instr_valid_reg <= 1'b0;
                instr_reg       <= NOP_INSTR;
            end
            case (state_reg)
                ST_ISSUE: begin
                    if (Request_Alt_PC) begin
                        if (IMEM_Ack) begin
                            pc_reg <= alt_aligned;
                        end else begin
                            redirect_pc_reg <= alt_aligned;
                            state_reg       <= ST_DRAIN;
                        end
                    end else if (WANT_FREEZE) begin
                        if (IMEM_Ack) begin
                            buf_instr_reg <= IMEM_Data;
                            buf_pc_reg    <= pc_reg;
                            pc_reg        <= pc_plus4;
                            state_reg     <= ST_FULL;
                        end
                    end else if (IMEM_Ack) begin
                        instr_reg          <= IMEM_Data;
                        instr_pc_reg       <= pc_reg;
                        instr_pc_plus4_reg <= pc_plus4;
                        instr_valid_reg    <= 1'b1;
                        pc_reg             <= pc_plus4;
                    end
                end
                ST_DRAIN: begin
                    // The stale response is never delivered. A redirect
                    // arriving together with it goes straight to the new
                    // target, otherwise the latest target is remembered.
                    if (IMEM_Ack) begin
                        pc_reg    <= Request_Alt_PC ? alt_aligned : redirect_pc_reg;
                        state_reg <= ST_ISSUE;
                    end else if (Request_Alt_PC) begin
                        redirect_pc_reg <= alt_aligned;
                    end
                end
                ST_FULL: begin
                    if (Request_Alt_PC) begin
                        pc_reg    <= alt_aligned;
                        state_reg <= ST_ISSUE;
                    end else if (!WANT_FREEZE) begin
                        instr_reg          <= buf_instr_reg;
                        instr_pc_reg       <= buf_pc_reg;
                        instr_pc_plus4_reg <= buf_pc_reg + 32'd4;
                        instr_valid_reg    <= 1'b1;
                        state_reg          <= ST_ISSUE;
                    end
                end
                default: begin
                    state_reg <= ST_ISSUE;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic squash_inc;

    assign fetch_inc  = (state_reg == ST_ISSUE) && IMEM_Ack && !Request_Alt_PC;
    assign squash_inc = ((state_reg == ST_ISSUE) && IMEM_Ack && Request_Alt_PC)
                     || ((state_reg == ST_DRAIN) && IMEM_Ack)
                     || ((state_reg == ST_FULL) && Request_Alt_PC);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Fetch_Count  <= 32'd0;
            Squash_Count <= 32'd0;
        end else begin
            if (fetch_inc) begin
                Fetch_Count <= Fetch_Count + 32'd1;
            end
            if (squash_inc) begin
                Squash_Count <= Squash_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch.
// Directed scenarios follow the fetch stage's documented behaviour; the
// random scenario checks the delivered instruction stream against a
// program-order model (expected next PC, redirect target, freeze hold).
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    logic        CLK;
    logic        RESET;
    logic [31:0] Alt_PC;
    logic        Request_Alt_PC;
    logic        WANT_FREEZE;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Req;
    logic        IMEM_Ack;
    logic [31:0] IMEM_Data;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Instr_Valid_OUT;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Fetch_Count;
    logic [31:0] Squash_Count;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0000;

    instr_fetch dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC             (Alt_PC),
        .Request_Alt_PC     (Request_Alt_PC),
        .WANT_FREEZE        (WANT_FREEZE),
        .IMEM_Addr          (IMEM_Addr),
        .IMEM_Req           (IMEM_Req),
        .IMEM_Ack           (IMEM_Ack),
        .IMEM_Data          (IMEM_Data),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Instr_Valid_OUT    (Instr_Valid_OUT)
`ifdef FETCH_PERF_CNT_EN
        ,
        .Fetch_Count        (Fetch_Count),
        .Squash_Count       (Squash_Count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs (data = current address ^ dxor when acking),
    // then advance past the next rising edge and settle.
    task automatic tick(input logic rst, input logic redir, input logic [31:0] alt,
                        input logic frz, input logic ack, input logic [31:0] dxor);
        RESET          = rst;
        Request_Alt_PC = redir;
        Alt_PC         = alt;
        WANT_FREEZE    = frz;
        IMEM_Ack       = ack;
        IMEM_Data      = ack ? (IMEM_Addr ^ dxor) : 32'hBAD0_BAD0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 32'h1111_0000);
        checks++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT} !== {NOP, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got instr=%h pc=%h pc4=%h v=%b, want %h 0 0 0",
                     Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, NOP);
        end
        checks++;
        if (IMEM_Req !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b want 0", IMEM_Req);
        end
        checks++;
        if (IMEM_Addr !== 32'h0040_0000) begin
            errors++;
            $display("FAIL reset_addr: got %h want 00400000", IMEM_Addr);
        end
        $display("reset: addr=%h req=%b valid=%b", IMEM_Addr, IMEM_Req, Instr_Valid_OUT);
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp = 32'h0040_0000 + 32'(4 * i);
            tick(0, 0, 0, 0, 1, 0);
            checks++;
            if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT} !== {exp, exp, exp + 32'd4, 1'b1}) begin
                errors++;
                $display("FAIL zero_wait_%0d: got instr=%h pc=%h pc4=%h v=%b, want %h %h %h 1",
                         i, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, exp, exp, exp + 32'd4);
            end
            $display("zero_wait: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
        end
        checks++;
        if ({IMEM_Req, IMEM_Addr} !== {1'b1, 32'h0040_0010}) begin
            errors++;
            $display("FAIL zero_wait_next: got req=%b addr=%h want 1 00400010", IMEM_Req, IMEM_Addr);
        end
    endtask

    task automatic test_wait_state();
        logic [31:0] exp;
        tick(1, 0, 0, 0, 0, 0);
        for (int t = 0; t < 2; t++) begin
            exp = 32'h0040_0000 + 32'(4 * t);
            for (int k = 0; k < 2; k++) begin
                tick(0, 0, 0, 0, 0, 0);
                checks++;
                if ({IMEM_Req, IMEM_Addr, Instr_Valid_OUT, Instr1_OUT} !== {1'b1, exp, 1'b0, NOP}) begin
                    errors++;
                    $display("FAIL wait_hold_%0d_%0d: got req=%b addr=%h v=%b instr=%h want 1 %h 0 %h",
                             t, k, IMEM_Req, IMEM_Addr, Instr_Valid_OUT, Instr1_OUT, exp, NOP);
                end
            end
            tick(0, 0, 0, 0, 1, 0);
            checks++;
            if ({Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT} !== {exp, exp, 1'b1}) begin
                errors++;
                $display("FAIL wait_deliver_%0d: got instr=%h pc=%h v=%b want %h %h 1",
                         t, Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT, exp, exp);
            end
            $display("wait_state: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
        end
    endtask

    task automatic test_redirect();
        // PC is 0x00400008 here; redirect with no ack -> drain stale request.
        tick(0, 1, 32'h0040_0103, 0, 0, 0);
        checks++;
        if ({Instr_Valid_OUT, Instr1_OUT, IMEM_Req, IMEM_Addr} !== {1'b0, NOP, 1'b1, 32'h0040_0008}) begin
            errors++;
            $display("FAIL redirect_drain: got v=%b instr=%h req=%b addr=%h want 0 %h 1 00400008",
                     Instr_Valid_OUT, Instr1_OUT, IMEM_Req, IMEM_Addr, NOP);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr_Valid_OUT, IMEM_Addr} !== {1'b0, 32'h0040_0100}) begin
            errors++;
            $display("FAIL redirect_discard: got v=%b addr=%h want 0 00400100", Instr_Valid_OUT, IMEM_Addr);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT} !== {32'h0040_0100, 32'h0040_0100, 32'h0040_0104, 1'b1}) begin
            errors++;
            $display("FAIL redirect_first: got instr=%h pc=%h pc4=%h v=%b want 00400100 00400100 00400104 1",
                     Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT);
        end
        $display("redirect: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
        // Redirect with a simultaneous ack: target valid one edge later.
        tick(0, 1, 32'h0040_0200, 0, 1, 0);
        checks++;
        if ({Instr_Valid_OUT, IMEM_Addr} !== {1'b0, 32'h0040_0200}) begin
            errors++;
            $display("FAIL redirect_ack: got v=%b addr=%h want 0 00400200", Instr_Valid_OUT, IMEM_Addr);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr_PC_OUT, Instr_Valid_OUT} !== {32'h0040_0200, 1'b1}) begin
            errors++;
            $display("FAIL redirect_latency: got pc=%h v=%b want 00400200 1", Instr_PC_OUT, Instr_Valid_OUT);
        end
        // PC wrap at the top of the address space.
        tick(0, 1, 32'hFFFF_FFFC, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, IMEM_Addr} !== {32'hFFFF_FFFC, 32'd0, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h pc4=%h v=%b addr=%h want fffffffc 0 1 0",
                     Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, IMEM_Addr);
        end
        $display("wrap: pc=%h pc4=%h next=%h", Instr_PC_OUT, Instr_PC_Plus4_OUT, IMEM_Addr);
    endtask

    task automatic test_freeze();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            tick(0, 0, 0, 1, (c == 0), 0);
            checks++;
            if ({Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT, IMEM_Req, IMEM_Addr} !==
                {32'h0040_0000, 32'h0040_0000, 1'b1, 1'b0, 32'h0040_0008}) begin
                errors++;
                $display("FAIL freeze_hold_%0d: got instr=%h pc=%h v=%b req=%b addr=%h want 00400000 00400000 1 0 00400008",
                         c, Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT, IMEM_Req, IMEM_Addr);
            end
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, IMEM_Req} !==
            {32'h0040_0004, 32'h0040_0004, 32'h0040_0008, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL freeze_release: got instr=%h pc=%h pc4=%h v=%b req=%b want 00400004 00400004 00400008 1 1",
                     Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT, IMEM_Req);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr_PC_OUT, Instr_Valid_OUT} !== {32'h0040_0008, 1'b1}) begin
            errors++;
            $display("FAIL freeze_next: got pc=%h v=%b want 00400008 1", Instr_PC_OUT, Instr_Valid_OUT);
        end
        $display("freeze: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
    endtask

    task automatic test_redirect_full();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1, 0);
        tick(0, 1, 32'h0040_0300, 1, 0, 0);
        checks++;
        if ({Instr_PC_OUT, Instr_Valid_OUT, IMEM_Req, IMEM_Addr} !== {32'h0040_0000, 1'b1, 1'b1, 32'h0040_0300}) begin
            errors++;
            $display("FAIL full_redirect: got pc=%h v=%b req=%b addr=%h want 00400000 1 1 00400300",
                     Instr_PC_OUT, Instr_Valid_OUT, IMEM_Req, IMEM_Addr);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if ({Instr_Valid_OUT, Instr1_OUT} !== {1'b0, NOP}) begin
            errors++;
            $display("FAIL full_dropped: got v=%b instr=%h want 0 %h", Instr_Valid_OUT, Instr1_OUT, NOP);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT} !== {32'h0040_0300, 32'h0040_0300, 1'b1}) begin
            errors++;
            $display("FAIL full_target: got instr=%h pc=%h v=%b want 00400300 00400300 1",
                     Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT);
        end
        $display("redirect_full: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1, 32'hFFFF_0000);
        checks++;
        if ({Instr_Valid_OUT, Instr_PC_OUT, IMEM_Addr} !== {1'b0, 32'd0, 32'h0040_0000}) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b pc=%h addr=%h want 0 0 00400000",
                     Instr_Valid_OUT, Instr_PC_OUT, IMEM_Addr);
        end
        tick(0, 0, 0, 0, 1, 0);
        checks++;
        if ({Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT} !== {32'h0040_0000, 32'h0040_0000, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_first: got instr=%h pc=%h v=%b want 00400000 00400000 1",
                     Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT);
        end
        $display("reset_mid: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
    endtask

    task automatic test_random();
        localparam logic [31:0] DXOR = 32'h1357_9BDF;
        logic [31:0] exp_pc, alt, p_instr, p_pc, p_pc4, p_addr;
        logic        p_valid, redir, frz, ack, p_wait, stalled;
        int          wait_cnt, idle;
        tick(1, 0, 0, 0, 0, 0);
        exp_pc   = 32'h0040_0000;
        wait_cnt = int'($urandom_range(0, 2));
        idle     = 0;
        stalled  = 1'b0;
        for (int n = 0; n < 1500 && !stalled; n++) begin
            p_instr = Instr1_OUT;
            p_pc    = Instr_PC_OUT;
            p_pc4   = Instr_PC_Plus4_OUT;
            p_valid = Instr_Valid_OUT;
            p_addr  = IMEM_Addr;
            redir   = ($urandom_range(0, 7) == 0);
            frz     = ($urandom_range(0, 3) == 0);
            alt     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : (32'h0040_0000 + 32'($urandom_range(0, 1023)));
            // Memory: each request is answered after 0..2 wait cycles.
            ack = 1'b0;
            if (IMEM_Req) begin
                if (wait_cnt == 0) begin
                    ack      = 1'b1;
                    wait_cnt = int'($urandom_range(0, 2));
                end else begin
                    wait_cnt--;
                end
            end
            p_wait = IMEM_Req && !ack;
            tick(0, redir, alt, frz, ack, DXOR);

            checks++;
            if (IMEM_Addr[1:0] !== 2'b00 || (p_wait && (IMEM_Req !== 1'b1 || IMEM_Addr !== p_addr))) begin
                errors++;
                $display("FAIL rnd_handshake_%0d: got req=%b addr=%h want addr stable %h while waiting",
                         n, IMEM_Req, IMEM_Addr, p_addr);
            end
            if (frz) begin
                checks++;
                if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, Instr_Valid_OUT} !== {p_instr, p_pc, p_pc4, p_valid}) begin
                    errors++;
                    $display("FAIL rnd_freeze_%0d: got instr=%h pc=%h v=%b want held %h %h %b",
                             n, Instr1_OUT, Instr_PC_OUT, Instr_Valid_OUT, p_instr, p_pc, p_valid);
                end
            end else if (redir || !Instr_Valid_OUT) begin
                checks++;
                if ({Instr_Valid_OUT, Instr1_OUT} !== {1'b0, NOP}) begin
                    errors++;
                    $display("FAIL rnd_bubble_%0d: got v=%b instr=%h want 0 %h", n, Instr_Valid_OUT, Instr1_OUT, NOP);
                end
            end else begin
                checks++;
                if ({Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT} !== {exp_pc ^ DXOR, exp_pc, exp_pc + 32'd4}) begin
                    errors++;
                    $display("FAIL rnd_deliver_%0d: got instr=%h pc=%h pc4=%h want %h %h %h",
                             n, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT, exp_pc ^ DXOR, exp_pc, exp_pc + 32'd4);
                end
                $display("rnd deliver: pc=%h instr=%h", Instr_PC_OUT, Instr1_OUT);
                exp_pc = exp_pc + 32'd4;
            end
            if (redir) begin
                exp_pc = {alt[31:2], 2'b00};
                idle   = 0;
            end else if (!frz) begin
                idle = Instr_Valid_OUT ? 0 : idle + 1;
                if (idle > 12) stalled = 1'b1;
            end
        end
        checks++;
        if (stalled) begin
            errors++;
            $display("FAIL rnd_progress: got %0d idle cycles want at most 12", idle);
        end
    endtask

    initial begin
        RESET          = 1'b1;
        Alt_PC         = 32'd0;
        Request_Alt_PC = 1'b0;
        WANT_FREEZE    = 1'b0;
        IMEM_Ack       = 1'b0;
        IMEM_Data      = 32'd0;
        #1;
        test_reset();
        test_zero_wait();
        test_wait_state();
        test_redirect();
        test_freeze();
        test_redirect_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
